// File: rtl/press_counter.sv
// Packed-BCD press counter fed by a debounced button level, with synchronous clear.
// Define PRESS_COUNTER_LONG_CLEAR_EN to compile in the long-press (hold) clear.
module press_counter #(
  parameter int DIGITS      = 2,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                  CLK,
  input  logic                  i_Rst_n,
  input  logic                  i_Button_State,
  input  logic                  i_Clear,
  output logic [4*DIGITS-1:0]   o_Count,
  output logic                  o_Press_Pulse,
  output logic                  o_Wrap,
  output logic                  o_Held
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] HELD    = 2'd2;

  logic                btn_q;
  logic [1:0]          state_reg;
  logic [1:0]          state_next;
  logic [4*DIGITS-1:0] count_reg;
  logic [4*DIGITS-1:0] count_next;
  logic [4*DIGITS-1:0] count_inc;
  logic                press_pulse_reg;
  logic                press_pulse_next;
  logic                wrap_reg;
  logic                wrap_next;
  logic [DIGITS:0]     carry;
  logic                press_edge;
  logic                hold_hit;

  // Out-of-range parameters leave an empty marker block in the elaborated hierarchy.
  if (HOLD_CYCLES < 2 || DIGITS < 1 || DIGITS > 8) begin : g_bad_params
  end

  assign press_edge = i_Button_State & ~btn_q;

  // Ripple-carry BCD increment; carry[DIGITS] means every digit was 9.
  assign carry[0] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bcd
    logic [3:0] digit;
    logic       at_nine;
    assign digit   = count_reg[4*gi +: 4];
    assign at_nine = (digit == 4'd9);
    assign count_inc[4*gi +: 4] = !carry[gi] ? digit
                                : (at_nine ? 4'd0 : digit + 4'd1);
    assign carry[gi+1] = carry[gi] & at_nine;
  end

`ifdef PRESS_COUNTER_LONG_CLEAR_EN
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [HOLD_W-1:0] hold_cnt_reg;

  assign hold_hit = (state_reg == PRESSED) && i_Button_State &&
                    (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1));

  always_ff @(posedge CLK or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hold_cnt_reg <= '0;
    end else if (press_edge) begin
      hold_cnt_reg <= '0;
    end else if (state_reg == PRESSED) begin
      hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
    end
  end

  assign o_Held = (state_reg == HELD);
`else
  assign hold_hit = 1'b0;
  assign o_Held   = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (press_edge) state_next = PRESSED;
      PRESSED: begin
        if (!i_Button_State) state_next = IDLE;
        else if (hold_hit)   state_next = HELD;
      end
      HELD:    if (!i_Button_State) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Clear beats long-press clear beats increment; the FSM advances regardless.
  always_comb begin
    count_next       = count_reg;
    press_pulse_next = 1'b0;
    wrap_next        = 1'b0;
    if (i_Clear) begin
      count_next = '0;
    end else if (hold_hit) begin
      count_next = '0;
    end else if (press_edge) begin
      count_next       = count_inc;
      press_pulse_next = 1'b1;
      wrap_next        = carry[DIGITS];
    end
  end

  // btn_q resets high so a button held through reset is not counted.
  always_ff @(posedge CLK or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      btn_q           <= 1'b1;
      state_reg       <= IDLE;
      count_reg       <= '0;
      press_pulse_reg <= 1'b0;
      wrap_reg        <= 1'b0;
    end else begin
      btn_q           <= i_Button_State;
      state_reg       <= state_next;
      count_reg       <= count_next;
      press_pulse_reg <= press_pulse_next;
      wrap_reg        <= wrap_next;
    end
  end

  assign o_Count       = count_reg;
  assign o_Press_Pulse = press_pulse_reg;
  assign o_Wrap        = wrap_reg;

endmodule

// File: tb/tb_press_counter.sv
// Directed bench for press_counter: a vector table plus hand-written multi-cycle sequences.
module tb_press_counter;

  localparam int DIGITS      = 2;
  localparam int HOLD_CYCLES = 8;

`ifdef PRESS_COUNTER_LONG_CLEAR_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       CLK            = 1'b0;
  logic       i_Rst_n        = 1'b0;
  logic       i_Button_State = 1'b1;
  logic       i_Clear        = 1'b0;
  logic [7:0] o_Count;
  logic       o_Press_Pulse;
  logic       o_Wrap;
  logic       o_Held;

  int checks = 0;
  int errors = 0;

  press_counter #(
    .DIGITS      (DIGITS),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .CLK            (CLK),
    .i_Rst_n        (i_Rst_n),
    .i_Button_State (i_Button_State),
    .i_Clear        (i_Clear),
    .o_Count        (o_Count),
    .o_Press_Pulse  (o_Press_Pulse),
    .o_Wrap         (o_Wrap),
    .o_Held         (o_Held)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       btn;
    logic       clr;
    logic [7:0] cnt;
    logic       pulse;
    logic       wrap;
    logic       held;
  } vec_t;

  vec_t vecs[13];
  logic [7:0] step_exp[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction: compare all four outputs and print one line.
  task automatic check_outs(input string name, input logic [7:0] cnt, input logic pulse,
                            input logic wrap, input logic held);
    $display("t=%0t %s count=%02h pulse=%0b wrap=%0b held=%0b", $time, name,
             o_Count, o_Press_Pulse, o_Wrap, o_Held);
    check({name, ".count"}, 32'(o_Count), 32'(cnt));
    check({name, ".pulse"}, 32'(o_Press_Pulse), 32'(pulse));
    check({name, ".wrap"},  32'(o_Wrap), 32'(wrap));
    check({name, ".held"},  32'(o_Held), 32'(held));
  endtask

  task automatic tick(input logic btn, input logic clr);
    @(negedge CLK);
    i_Button_State = btn;
    i_Clear        = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic presses(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] long_cnt;

    // btn, clr, count, pulse, wrap, held
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

    step_exp = '{8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};

    // Reset with the button held high.
    repeat (2) @(posedge CLK);
    #1;
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    i_Rst_n = 1'b1;

    for (int v = 0; v < 13; v++) begin
      tick(vecs[v].btn, vecs[v].clr);
      check_outs($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].pulse, vecs[v].wrap, vecs[v].held);
    end

    // BCD stepping across a digit carry, 3 high / 2 low.
    presses(8);
    check_outs("pre08", 8'h08, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b0);
      check_outs($sformatf("step%0d", k), step_exp[k], 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0);
      check_outs($sformatf("step%0d_hi", k), step_exp[k], 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
    end

    // Full-scale rollover.
    tick(1'b0, 1'b1);
    check_outs("clr_a", 8'h00, 1'b0, 1'b0, 1'b0);
    presses(99);
    check_outs("pre99", 8'h99, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check_outs("wrap", 8'h00, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check_outs("wrap_after", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Long press from 0x05, button high for 12 edges.
    tick(1'b0, 1'b1);
    presses(5);
    check_outs("pre05", 8'h05, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check_outs("hold_n", 8'h06, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < HOLD_CYCLES; i++) begin
      tick(1'b1, 1'b0);
      check_outs($sformatf("hold_n+%0d", i), 8'h06, 1'b0, 1'b0, 1'b0);
    end
    long_cnt = LONG_EN ? 8'h00 : 8'h06;
    for (int i = HOLD_CYCLES; i < 12; i++) begin
      tick(1'b1, 1'b0);
      check_outs($sformatf("hold_n+%0d", i), long_cnt, 1'b0, 1'b0, LONG_EN);
    end
    tick(1'b0, 1'b0);
    check_outs("hold_release", long_cnt, 1'b0, 1'b0, 1'b0);

    // Clear coincident with a press edge at 0x42.
    tick(1'b0, 1'b1);
    presses(42);
    check_outs("pre42", 8'h42, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1);
    check_outs("clr_press", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check_outs("clr_press_hi", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check_outs("press_before_rst", 8'h01, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-press, between clock edges.
    #2;
    i_Rst_n = 1'b0;
    #1;
    check_outs("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    i_Rst_n = 1'b1;
    tick(1'b1, 1'b0);
    check_outs("held_thru_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check_outs("press_after_rst", 8'h01, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/press_counter.md
# press_counter

Consumes the debounced button level from the debounce stage and counts presses as a packed-BCD value. Each clean rising edge increments the count by one; the count wraps from all nines back to zero. A synchronous clear and an optional long-press clear reset the count. The block sits between the debouncer and the display driver. Its outputs are registered so the display logic can sample them directly.

## Interface
- DIGITS, 2: number of BCD digits in the count (1–8).
- HOLD_CYCLES, 50_000_000: cycles the button must stay high after a counted press to trigger a long-press clear. Must be ≥ 2.
- CLK  input  1  system clock; all logic is on the rising edge.
- i_Rst_n  input  1  reset: one clock, asynchronous assert, active-low.
- i_Button_State  input  1  debounced button level, already synchronous to CLK; 1 = pressed.
- i_Clear  input  1  synchronous clear of the count; level, sampled each cycle.
- o_Count  output  4*DIGITS  packed BCD count; digit 0 is in [3:0].
- o_Press_Pulse  output  1  one-cycle strobe: a press was counted.
- o_Wrap  output  1  one-cycle strobe: the count rolled over from all 9s to 0.
- o_Held  output  1  level: long-press clear is active; stays high until release.

## Operation
- Edge detect: register btn_q samples i_Button_State every cycle. A press edge is i_Button_State=1 while btn_q=0.
- State machine:
  - IDLE → PRESSED on a press edge.
  - PRESSED → IDLE when i_Button_State=0.
  - PRESSED → HELD when hold_cnt reaches HOLD_CYCLES-1 while the button is still high.
  - HELD → IDLE when i_Button_State=0.
- Hold counter:
  - hold_cnt is $clog2(HOLD_CYCLES) bits wide.
  - Loaded to 0 on the press edge; increments each cycle in PRESSED.
  - Does not saturate past the threshold, because the state leaves PRESSED at the threshold.
- Count update on a press edge:
  - BCD increment with ripple carry: a digit at 9 becomes 0 and carries into the next digit.
  - All digits at 9 roll over to all 0 and assert o_Wrap.
  - No digit ever holds a value of A–F.
- Priority, highest first:
  1. i_Rst_n low.
  2. i_Clear high.
  3. Long-press clear.
  4. Press increment.
- i_Clear in the same cycle as a press edge: the count goes to 0, o_Press_Pulse and o_Wrap stay low, and the FSM still enters PRESSED.
- Entering HELD sets the count to 0, with no o_Press_Pulse and no o_Wrap.
- No press can be counted in PRESSED or HELD, because btn_q stays 1 there.

## Timing
- Reset values:
  - o_Count=0, o_Press_Pulse=0, o_Wrap=0, o_Held=0.
  - State=IDLE, hold_cnt=0.
  - btn_q=1, so a button already held when reset is released is not counted until it is released and pressed again.
- Press latency: if i_Button_State rises before edge N, o_Count, o_Press_Pulse and o_Wrap update at edge N. Each strobe lasts exactly one cycle.
- Long press:
  - The press edge is at N.
  - The HELD entry edge is N+HOLD_CYCLES, provided the button is high through edge N+HOLD_CYCLES.
  - The count is 0 and o_Held=1 from that edge.
  - o_Held drops on the edge that samples i_Button_State=0.
- Release in PRESSED at any hold_cnt below the threshold: return to IDLE on that edge; the count keeps its incremented value.
- Back-to-back presses: the minimum spacing is one low sample. A 1-0-1 pattern on consecutive cycles counts 2.
- Asynchronous reset during PRESSED or HELD: all state returns to reset values immediately, with no glitch pulse on the strobes.

## Configuration
- PRESS_COUNTER_LONG_CLEAR_EN defined:
  - The hold counter, the HELD state and the long-press clear are compiled in.
  - o_Held behaves as described above.
- PRESS_COUNTER_LONG_CLEAR_EN not defined:
  - No hold counter and no HELD state.
  - PRESSED is left only on release, however long the button is held.
  - o_Held is tied to 0.
  - HOLD_CYCLES is ignored.
  - All other behaviour is identical.

## Test plan
Bench overrides: DIGITS=2, HOLD_CYCLES=8, macro defined unless stated.
- Reset with the button held high, then release reset: o_Count=0x00 until the button goes 0→1; then o_Count=0x01 and o_Press_Pulse high for exactly one cycle.
- 10 presses, each 3 cycles high and 2 low, from 0x08: o_Count steps through 0x09, 0x10, 0x11 … 0x18. BCD carry is correct and no hex digits appear.
- Preload to 0x99 by 99 presses, then 1 more press: o_Count=0x00, with o_Wrap and o_Press_Pulse high in the same single cycle.
- Count at 0x05, then the button held 12 cycles: o_Count=0x06 at the press; o_Count=0x00 and o_Held=1 eight edges later; o_Held=0 on release; no extra pulse.
- Same 12-cycle hold with the macro undefined: o_Count stays 0x06 and o_Held is never asserted.
- i_Clear on the same cycle as a press edge at count 0x42: o_Count=0x00 and no pulse. Pulling i_Rst_n low mid-press clears all outputs asynchronously.
